// File: rtl/fx_div_credit_buf_pkg.sv
// Shared fixed-point configuration for the divider and its credit-gated result buffer.
package fx_div_credit_buf_pkg;

  localparam int unsigned FP_WIDTH       = 32;
  localparam int unsigned FP_DIV_LATENCY = 16;
  localparam int unsigned DIV_BUF_DEPTH  = 32;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fx_fifo_mem.sv
// Result storage for the divider buffer: one synchronous write port, one asynchronous read port.
module fx_fifo_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately left unreset; occupancy tracking guards every read.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fx_div_credit_buf.sv
// Credit-gated issue/return buffer around the fixed-point divider: a pair is issued only when a
// result slot is reserved, so the divider never needs back-pressure.
module fx_div_credit_buf
  import fx_div_credit_buf_pkg::*;
#(
  parameter int unsigned WIDTH   = FP_WIDTH,
  parameter int unsigned DEPTH   = DIV_BUF_DEPTH,
  parameter int unsigned LATENCY = FP_DIV_LATENCY
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid_in,
  output logic                     issue_ready_out,
  output logic                     div_valid_out,
  input  logic                     div_ready_in,
  input  logic                     div_res_valid_in,
  input  logic [WIDTH-1:0]         div_res_in,
  output logic                     div_res_ready_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [WIDTH-1:0]         result_out,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic [$clog2(DEPTH):0]   inflight_out,
  output logic                     overflow_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (!is_pow2(DEPTH)) begin : g_depth_chk
    $error("fx_div_credit_buf: DEPTH must be a power of 2");
  end
  if (DEPTH < LATENCY + 1) begin : g_lat_chk
    $warning("fx_div_credit_buf: DEPTH < LATENCY+1 cannot sustain one issue per clock");
  end

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    occ_q, occ_d, infl_q, infl_d;
  logic             ovf_q, ovf_d;
  logic [CW:0]      used;
  logic             not_empty, rd_fire, has_credit, iss_fire, ret_err, ret_ok;
  logic [WIDTH-1:0] head;

  fx_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (ret_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (div_res_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // A slot freed by a same-cycle read counts as credit, so a full buffer can read and issue together.
  always_comb begin
    not_empty  = ~rst & (occ_q != '0);
    rd_fire    = not_empty & ready_in;
    used       = {1'b0, occ_q} + {1'b0, infl_q} - (CW+1)'(rd_fire);
    has_credit = used < (CW+1)'(DEPTH);
    iss_fire   = ~rst & issue_valid_in & div_ready_in & has_credit;
    ret_err    = div_res_valid_in & ((infl_q == '0) | ((occ_q == CW'(DEPTH)) & ~rd_fire));
    ret_ok     = ~rst & div_res_valid_in & ~ret_err;

    wr_ptr_d = wr_ptr_q + AW'(ret_ok);
    rd_ptr_d = rd_ptr_q + AW'(rd_fire);
    occ_d    = occ_q + CW'(ret_ok) - CW'(rd_fire);
    infl_d   = infl_q + CW'(iss_fire) - CW'(ret_ok);
    ovf_d    = ovf_q | ret_err;
  end

  always_comb begin
    issue_ready_out   = ~rst & div_ready_in & has_credit;
    div_valid_out     = ~rst & issue_valid_in & has_credit;
    div_res_ready_out = ~rst;
    valid_out         = not_empty;
    result_out        = not_empty ? head : '0;
    count_out         = occ_q;
    inflight_out      = infl_q;
    overflow_err      = ovf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      infl_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      ovf_q    <= ovf_d;
    end
  end

  a_credit_bound : assert property (@(posedge clk) disable iff (rst)
    ({1'b0, occ_q} + {1'b0, infl_q}) <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_fx_div_credit_buf.sv
// Scoreboard bench for fx_div_credit_buf with a fixed-latency divider model (result = n/2).
module tb_fx_div_credit_buf;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned LAT   = 16;
  localparam int unsigned CW    = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid_in, issue_ready_out, div_valid_out, div_ready_in;
  logic          div_res_valid_in, div_res_ready_out, valid_out, ready_in, overflow_err;
  logic [W-1:0]  div_res_in, result_out;
  logic [CW-1:0] count_out, inflight_out;

  typedef struct { int due; logic [W-1:0] data; } ret_t;
  ret_t         pipe_q[$];
  logic [W-1:0] exp_q[$];

  int   checks = 0, failures = 0, cyc = 0, next_n = 0, rx_cnt = 0;
  int   stalls, peak, n0, rx0;
  logic fire, rd;

  fx_div_credit_buf #(.WIDTH(W), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk               (clk),
    .rst               (rst),
    .issue_valid_in    (issue_valid_in),
    .issue_ready_out   (issue_ready_out),
    .div_valid_out     (div_valid_out),
    .div_ready_in      (div_ready_in),
    .div_res_valid_in  (div_res_valid_in),
    .div_res_in        (div_res_in),
    .div_res_ready_out (div_res_ready_out),
    .valid_out         (valid_out),
    .ready_in          (ready_in),
    .result_out        (result_out),
    .count_out         (count_out),
    .inflight_out      (inflight_out),
    .overflow_err      (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // One clock of stimulus: inputs change on the falling edge, outputs sampled 1 time unit later.
  task automatic drive(input logic iv, input logic rdy, input logic rv,
                       input logic [W-1:0] rdata, input bit push);
    @(negedge clk);
    issue_valid_in   = iv;
    ready_in         = rdy;
    div_res_valid_in = rv;
    div_res_in       = rdata;
    if (rv && push) exp_q.push_back(rdata);
    #1;
    fire = issue_valid_in & issue_ready_out;
    rd   = valid_out & ready_in;
    cyc++;
  endtask

  task automatic run_cycle(input logic iv, input logic rdy);
    logic         rv;
    logic [W-1:0] d;
    int           c;
    rv = 1'b0;
    d  = '0;
    c  = cyc;
    if (pipe_q.size() != 0 && pipe_q[0].due <= c) begin
      rv = 1'b1;
      d  = pipe_q[0].data;
      void'(pipe_q.pop_front());
    end
    drive(iv, rdy, rv, d, 1'b1);
    if (fire) begin
      pipe_q.push_back('{due: c + int'(LAT), data: W'(next_n / 2)});
      next_n++;
    end
    if (int'(inflight_out) > peak) peak = int'(inflight_out);
  endtask

  task automatic monitor();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_unexpected: actual=0x%0h required=no output", result_out);
        end else begin
          e = exp_q.pop_front();
          chk("scoreboard_result", longint'(result_out), longint'(e));
          rx_cnt++;
        end
      end
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    issue_valid_in   = 1'b1;
    div_ready_in     = 1'b1;
    ready_in         = 1'b1;
    div_res_valid_in = 1'b0;
    rst              = 1'b1;
    #1;
    chk({tag, "_rst_issue_ready"}, longint'(issue_ready_out), 0);
    chk({tag, "_rst_div_valid"},   longint'(div_valid_out), 0);
    chk({tag, "_rst_res_ready"},   longint'(div_res_ready_out), 0);
    chk({tag, "_rst_valid"},       longint'(valid_out), 0);
    chk({tag, "_rst_result"},      longint'(result_out), 0);
    chk({tag, "_rst_count"},       longint'(count_out), 0);
    chk({tag, "_rst_inflight"},    longint'(inflight_out), 0);
    chk({tag, "_rst_ovf"},         longint'(overflow_err), 0);
    exp_q.delete();
    pipe_q.delete();
    @(negedge clk);
    rst            = 1'b0;
    issue_valid_in = 1'b0;
    ready_in       = 1'b0;
    #1;
    chk({tag, "_post_count"},     longint'(count_out), 0);
    chk({tag, "_post_inflight"},  longint'(inflight_out), 0);
    chk({tag, "_post_ovf"},       longint'(overflow_err), 0);
    chk({tag, "_post_res_ready"}, longint'(div_res_ready_out), 1);
  endtask

  initial begin
    issue_valid_in   = 1'b0;
    ready_in         = 1'b0;
    div_ready_in     = 1'b1;
    div_res_valid_in = 1'b0;
    div_res_in       = '0;
    fork
      monitor();
      begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    do_reset("init");

    // Mid-stream reset with five in flight and three held.
    repeat (8) drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h1111_0000, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 32'h2222_0000, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 32'h3333_0000, 1'b1);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("t1_pre_count", longint'(count_out), 3);
    chk("t1_pre_inflight", longint'(inflight_out), 5);
    do_reset("t1");

    // 100 back-to-back issues with downstream always ready.
    stalls = 0;
    peak   = 0;
    for (int i = 0; i < 100; i++) begin
      run_cycle(1'b1, 1'b1);
      if (!fire) stalls++;
      if (i == 0) chk("t2_div_valid", longint'(div_valid_out), 1);
    end
    for (int i = 0; i < 100 && !(pipe_q.size() == 0 && count_out == '0 && inflight_out == '0); i++)
      run_cycle(1'b0, 1'b1);
    chk("t2_drained", longint'(pipe_q.size() == 0 && count_out == '0 && inflight_out == '0), 1);
    chk("t2_issued", next_n, 100);
    chk("t2_stalls", stalls, 0);
    chk("t2_peak_inflight", peak, 16);
    chk("t2_results", rx_cnt, 100);
    chk("t2_exp_empty", exp_q.size(), 0);
    chk("t2_ovf", longint'(overflow_err), 0);

    // Downstream stalled: credit allows exactly DEPTH issues.
    n0  = next_n;
    rx0 = rx_cnt;
    for (int i = 0; i < 60; i++) run_cycle(1'b1, 1'b0);
    chk("t3_issued", next_n - n0, 32);
    chk("t3_issue_ready", longint'(issue_ready_out), 0);
    chk("t3_div_valid", longint'(div_valid_out), 0);
    chk("t3_count", longint'(count_out), 32);
    chk("t3_inflight", longint'(inflight_out), 0);
    chk("t3_ovf", longint'(overflow_err), 0);
    chk("t3_no_reads", rx_cnt - rx0, 0);

    // Full buffer: one read frees a slot for a same-cycle issue.
    run_cycle(1'b1, 1'b1);
    chk("t4_issue_fire", longint'(fire), 1);
    chk("t4_read_fire", longint'(rd), 1);
    run_cycle(1'b0, 1'b0);
    chk("t4_count", longint'(count_out), 31);
    chk("t4_inflight", longint'(inflight_out), 1);
    for (int i = 0; i < 100 && !(pipe_q.size() == 0 && count_out == '0 && inflight_out == '0); i++)
      run_cycle(1'b0, 1'b1);
    chk("t4_results", rx_cnt - rx0, 33);
    chk("t4_exp_empty", exp_q.size(), 0);

    // Spurious return with nothing in flight.
    drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("t5_ovf_set", longint'(overflow_err), 1);
    chk("t5_count", longint'(count_out), 0);
    chk("t5_valid", longint'(valid_out), 0);
    repeat (4) drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("t5_ovf_sticky", longint'(overflow_err), 1);
    do_reset("t5");

    // Return and read in the same cycle at occupancy 1.
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h0001_8000, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_0000, 1'b1);
    chk("t6_valid_before", longint'(valid_out), 1);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("t6_valid_after", longint'(valid_out), 1);
    chk("t6_result", longint'(result_out), 64'hFFFF_0000);
    chk("t6_count", longint'(count_out), 1);
    chk("t6_inflight", longint'(inflight_out), 0);
    drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("t6_count_end", longint'(count_out), 0);
    chk("t6_exp_empty", exp_q.size(), 0);
    chk("t6_ovf", longint'(overflow_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
